// File: rtl/note_timer_pkg.sv
// Shared definitions for the note timer and the sequencer around it.
// Holds the phase encoding and the default field sizes.
package note_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int DUR_W_DEF = 8;
    localparam int GAP_DEF   = 2;

endpackage

// File: rtl/note_timer_tick_downcnt.sv
// Loadable down-counter that steps once per enabled tick.
// Saturates at zero so the count can never wrap.
module tick_downcnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // load has priority; decrement only while non-zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/note_timer.sv
// Plays one note: sound for dur ticks, then a release gap of GAP ticks.
// One shared down-counter times both the note and the gap phase.
module note_timer
    import note_timer_pkg::*;
#(
    parameter int DUR_W = DUR_W_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic [DUR_W-1:0] dur,
    input  logic             abort,
    output logic             note_on,
    output logic             busy,
    output logic             done,
    output logic [DUR_W-1:0] remaining
);

    localparam logic [DUR_W-1:0] GAP_V = DUR_W'(GAP);

    state_t           state;
    state_t           state_nx;
    logic             cnt_load;
    logic [DUR_W-1:0] cnt_val;
    logic             cnt_dec;
    logic [DUR_W-1:0] count;
    logic             cnt_zero;
    logic             expire;
    logic             note_on_nx;
    logic             busy_nx;
    logic             done_nx;

    tick_downcnt #(
        .W(DUR_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (count),
        .zero     (cnt_zero)
    );

    // The phase ends on the tick that consumes its last count
    assign expire = cnt_zero || (tick && (count == DUR_W'(1)));

    // Phase register plus registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            note_on <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            note_on <= note_on_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

    // Next phase and counter control; abort beats any tick
    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    cnt_load = 1'b1;
                    if (dur != '0) begin
                        state_nx = ST_NOTE;
                        cnt_val  = dur;
                    end else begin
                        state_nx = ST_FIN;
                    end
                end
            end
            ST_NOTE: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                    cnt_load = 1'b1;
                end else if (expire) begin
                    cnt_load = 1'b1;
                    if (GAP_V != '0) begin
                        state_nx = ST_GAP;
                        cnt_val  = GAP_V;
                    end else begin
                        state_nx = ST_FIN;
                    end
                end else begin
                    cnt_dec = tick;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                    cnt_load = 1'b1;
                end else if (expire) begin
                    state_nx = ST_FIN;
                    cnt_load = 1'b1;
                end else begin
                    cnt_dec = tick;
                end
            end
            ST_FIN: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_load = 1'b1;
            end
        endcase
    end

    // Output values for the phase being entered
    always_comb begin
        note_on_nx = (state_nx == ST_NOTE);
        busy_nx    = (state_nx != ST_IDLE);
        done_nx    = (state_nx == ST_FIN);
    end

    assign remaining = count;

endmodule

// File: tb/tb_note_timer.sv
// Bench for note_timer: two instances (GAP=2 and GAP=0) share stimulus.
// A tick-count model predicts every output each cycle.
module tb_note_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] dur = 8'd0;

    logic       a_note_on, a_busy, a_done;
    logic [7:0] a_rem;
    logic       b_note_on, b_busy, b_done;
    logic [7:0] b_rem;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;
    int on_cnt_b = 0;

    int rem_note [2];
    int rem_gap  [2];
    bit fin      [2];
    int gapv     [2] = '{2, 0};

    always #5 clk = ~clk;

    note_timer #(.DUR_W(8), .GAP(2)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .dur       (dur),
        .abort     (abort),
        .note_on   (a_note_on),
        .busy      (a_busy),
        .done      (a_done),
        .remaining (a_rem)
    );

    note_timer #(.DUR_W(8), .GAP(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .dur       (dur),
        .abort     (abort),
        .note_on   (b_note_on),
        .busy      (b_busy),
        .done      (b_done),
        .remaining (b_rem)
    );

    task automatic check(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int m_note_on(input int i);
        return (rem_note[i] > 0) ? 1 : 0;
    endfunction

    function automatic int m_busy(input int i);
        return (rem_note[i] > 0 || rem_gap[i] > 0 || fin[i]) ? 1 : 0;
    endfunction

    function automatic int m_rem(input int i);
        return (rem_note[i] > 0) ? rem_note[i] : rem_gap[i];
    endfunction

    // model: what is left of note and gap, and whether we are finishing
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rem_note[i] = 0;
                rem_gap[i]  = 0;
                fin[i]      = 1'b0;
            end else if (fin[i]) begin
                fin[i] = 1'b0;
            end else if (rem_note[i] > 0) begin
                if (abort) begin
                    rem_note[i] = 0;
                end else if (tick) begin
                    rem_note[i] = rem_note[i] - 1;
                    if (rem_note[i] == 0) begin
                        if (gapv[i] > 0) rem_gap[i] = gapv[i];
                        else fin[i] = 1'b1;
                    end
                end
            end else if (rem_gap[i] > 0) begin
                if (abort) begin
                    rem_gap[i] = 0;
                end else if (tick) begin
                    rem_gap[i] = rem_gap[i] - 1;
                    if (rem_gap[i] == 0) fin[i] = 1'b1;
                end
            end else if (start && !abort) begin
                if (dur != 8'd0) rem_note[i] = int'(dur);
                else fin[i] = 1'b1;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("a.note_on", int'(a_note_on), m_note_on(0));
            check("a.busy", int'(a_busy), m_busy(0));
            check("a.done", int'(a_done), int'(fin[0]));
            check("a.remaining", int'(a_rem), m_rem(0));
            check("b.note_on", int'(b_note_on), m_note_on(1));
            check("b.busy", int'(b_busy), m_busy(1));
            check("b.done", int'(b_done), int'(fin[1]));
            check("b.remaining", int'(b_rem), m_rem(1));
            if (b_note_on) on_cnt_b++;
        end
    end

    task automatic cyc(input bit t, input bit s, input int d,
                       input bit a, input bit r);
        tick  = t;
        start = s;
        dur   = d[7:0];
        abort = a;
        rst   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 3, 1, 1);
        chk_on = 1'b1;
        check("rst.busy", int'(a_busy), 0);
        check("rst.note_on", int'(a_note_on), 0);
        check("rst.done", int'(a_done), 0);
        check("rst.rem", int'(a_rem), 0);

        // dur=3, tick every 4 cycles, start coincides with a tick
        cyc(1, 1, 3, 0, 0);
        check("s1.rem", int'(a_rem), 3);
        check("s1.on", int'(a_note_on), 1);
        for (int k = 1; k <= 5; k++) begin
            repeat (3) cyc(0, 0, 0, 0, 0);
            cyc(1, 0, 0, 0, 0);
            if (k == 3) begin
                check("s1.gap_on", int'(a_note_on), 0);
                check("s1.gap_rem", int'(a_rem), 2);
                check("s1.b_done", int'(b_done), 1);
            end
        end
        check("s1.done", int'(a_done), 1);
        cyc(0, 0, 0, 0, 0);
        check("s1.idle_busy", int'(a_busy), 0);
        check("s1.idle_done", int'(a_done), 0);

        // zero-length note
        cyc(0, 1, 0, 0, 0);
        check("s2.done", int'(a_done), 1);
        check("s2.busy", int'(a_busy), 1);
        check("s2.on", int'(a_note_on), 0);
        cyc(0, 0, 0, 0, 0);
        check("s2.busy_off", int'(a_busy), 0);

        // abort together with the third tick
        cyc(0, 1, 5, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("s3.rem", int'(a_rem), 3);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        check("s3.busy", int'(a_busy), 0);
        check("s3.rem0", int'(a_rem), 0);
        check("s3.done", int'(a_done), 0);
        cyc(0, 0, 0, 0, 0);

        // start while busy is ignored
        cyc(0, 1, 6, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 4, 0, 0);
        check("s4.rem", int'(a_rem), 5);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 4, 0, 0);
            cyc(1, 0, 0, 0, 0);
        end
        check("s4.gap_rem", int'(a_rem), 2);
        check("s4.gap_on", int'(a_note_on), 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("s4.done", int'(a_done), 1);
        cyc(0, 0, 0, 0, 0);

        // start during FIN, abort+start in IDLE, abort during FIN
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 2, 0, 0);
        check("s5.fin_start", int'(a_busy), 0);
        cyc(0, 1, 2, 0, 0);
        check("s5.on", int'(a_note_on), 1);
        check("s5.rem", int'(a_rem), 2);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 3, 1, 0);
        check("s5.abort_start", int'(a_busy), 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // reset mid-gap, then dur=1 on the GAP=0 instance
        cyc(0, 1, 4, 0, 0);
        repeat (4) cyc(1, 0, 0, 0, 0);
        check("s6.in_gap", int'(a_rem), 2);
        cyc(1, 1, 7, 1, 1);
        check("s6.rst_busy", int'(a_busy), 0);
        check("s6.rst_rem", int'(a_rem), 0);
        check("s6.rst_on", int'(a_note_on), 0);
        cyc(0, 1, 1, 0, 0);
        check("s6.b_on", int'(b_note_on), 1);
        cyc(1, 0, 0, 0, 0);
        check("s6.b_done", int'(b_done), 1);
        cyc(0, 0, 0, 0, 1);

        // continuous tick, dur=255
        on_cnt_b = 0;
        cyc(1, 1, 255, 0, 0);
        repeat (259) cyc(1, 0, 0, 0, 0);
        check("s7.on_cycles", on_cnt_b, 255);
        check("s7.busy", int'(b_busy), 0);
        repeat (2) cyc(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
